// File: rtl/pgm_gfx_fetch_pkg.sv
// Shared definitions for the graphics-ROM fetch path: DDRAM port widths,
// the fetch FSM encoding and the request-length clamp.
package pgm_pkg;

   localparam int DDRAM_AW = 29;
   localparam int DDRAM_DW = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } fetch_st_t;

   // A zero length still fetches one beat; anything past the limit is cut to the limit.
   function automatic logic [7:0] clamp_len(input logic [3:0] len, input logic [7:0] max_len);
      logic [7:0] l;
      if (len == 4'd0) begin
         l = 8'd1;
      end else begin
         l = {4'b0000, len};
      end
      if (l > max_len) begin
         l = max_len;
      end else begin
         l = l;
      end
      return l;
   endfunction

endpackage

// File: rtl/pgm_gfx_fetch_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head, occupancy count
// and a single-cycle clear. Also used by the sprite engine.
module pgm_sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic                      head_valid,
   output logic [WIDTH-1:0]          head_data,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C  = (AW+1)'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign count      = wr_ptr_r - rd_ptr_r;
   assign do_push_s  = push && (count != FULL_C);
   assign do_pop_s   = pop && (count != {(AW+1){1'b0}});
   assign head_valid = (count != {(AW+1){1'b0}});
   // Data is gated so an empty FIFO always presents zeros, including straight after reset.
   assign head_data  = head_valid ? mem_r[rd_ptr_r[AW-1:0]] : {WIDTH{1'b0}};

   // Pointer update; clear wins over any push or pop in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (do_push_s && !clear) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/pgm_gfx_fetch.sv
// Graphics-ROM fetch engine: turns renderer tile-row requests into DDRAM burst
// reads and buffers returned beats in a credit-guarded FIFO.
module pgm_gfx_fetch
   import pgm_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_BURST  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [28:0]          req_addr,
   input  logic [3:0]           req_len,
   output logic                 ddram_rd,
   output logic [28:0]          ddram_addr,
   output logic [7:0]           ddram_burstcnt,
   input  logic                 ddram_busy,
   input  logic [63:0]          ddram_dout,
   input  logic                 ddram_dout_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_data,
   output logic                 out_last
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0]    MAX_LEN_C = 8'(MAX_BURST);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   fetch_st_t     state_r, state_s;
   logic [7:0]    len_r, len_s;
   logic [7:0]    beats_left_r, beats_left_s;
   logic [7:0]    discard_r, discard_s;
   logic [CW-1:0] pending_r, pending_s;
   logic          flush_hold_r, flush_hold_s;
   logic          run_r;
   logic          rd_r, rd_s;
   logic [28:0]   addr_r, addr_s;
   logic [7:0]    bcnt_r, bcnt_s;

   logic [7:0]    len_eff_s;
   logic [CW-1:0] fifo_count_s;
   logic [CW-1:0] free_s;
   logic          beat_s, last_beat_s, push_s, pop_s, accept_s;
   logic          fifo_valid_s;
   logic [64:0]   fifo_head_s;

   assign len_eff_s   = clamp_len(req_len, MAX_LEN_C);
   assign free_s      = DEPTH_C - fifo_count_s - pending_r;
   assign beat_s      = ddram_dout_ready && (state_r == DATA);
   assign last_beat_s = beat_s && (beats_left_r == 8'd1);
   assign push_s      = beat_s && !flush;
   assign pop_s       = out_ready && fifo_valid_s && !flush;
   // A new request may also be taken in the cycle the current burst's last beat lands.
   assign req_ready   = run_r && !flush && (32'(free_s) >= 32'(len_eff_s))
                        && ((state_r == IDLE) || last_beat_s);
   assign accept_s    = req_valid && req_ready;

   pgm_sync_fifo #(
      .WIDTH (DDRAM_DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .push       (push_s),
      .push_data  ({last_beat_s, ddram_dout}),
      .pop        (pop_s),
      .head_valid (fifo_valid_s),
      .head_data  (fifo_head_s),
      .count      (fifo_count_s)
   );

   // Next-state and credit bookkeeping for the fetch FSM.
   always_comb begin
      state_s      = state_r;
      len_s        = len_r;
      beats_left_s = beats_left_r;
      discard_s    = discard_r;
      pending_s    = pending_r;
      flush_hold_s = flush_hold_r;
      rd_s         = rd_r;
      addr_s       = addr_r;
      bcnt_s       = bcnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s      = ISSUE;
               len_s        = len_eff_s;
               beats_left_s = len_eff_s;
               pending_s    = pending_r + CW'(len_eff_s);
               rd_s         = 1'b1;
               addr_s       = req_addr;
               bcnt_s       = len_eff_s;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            // The command cannot be withdrawn, so a flush here is remembered until it is taken.
            if (!ddram_busy) begin
               rd_s         = 1'b0;
               flush_hold_s = 1'b0;
               if (flush || flush_hold_r) begin
                  state_s   = DRAIN;
                  discard_s = len_r;
                  pending_s = CW'(len_r);
               end else begin
                  state_s = DATA;
               end
            end else begin
               flush_hold_s = flush_hold_r | flush;
            end
         end
         DATA: begin
            if (flush) begin
               discard_s = beats_left_r - (beat_s ? 8'd1 : 8'd0);
               pending_s = CW'(discard_s);
               state_s   = (discard_s == 8'd0) ? IDLE : DRAIN;
            end else if (beat_s) begin
               beats_left_s = beats_left_r - 8'd1;
               pending_s    = pending_r - ONE_C;
               if (beats_left_r == 8'd1) begin
                  if (accept_s) begin
                     state_s      = ISSUE;
                     len_s        = len_eff_s;
                     beats_left_s = len_eff_s;
                     pending_s    = pending_r - ONE_C + CW'(len_eff_s);
                     rd_s         = 1'b1;
                     addr_s       = req_addr;
                     bcnt_s       = len_eff_s;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  state_s = DATA;
               end
            end else begin
               state_s = DATA;
            end
         end
         DRAIN: begin
            if (ddram_dout_ready && (discard_r > 8'd1)) begin
               discard_s = discard_r - 8'd1;
               pending_s = CW'(discard_s);
            end else if (ddram_dout_ready || (discard_r == 8'd0)) begin
               discard_s = 8'd0;
               pending_s = {CW{1'b0}};
               state_s   = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and command registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         len_r        <= 8'd0;
         beats_left_r <= 8'd0;
         discard_r    <= 8'd0;
         pending_r    <= {CW{1'b0}};
         flush_hold_r <= 1'b0;
         run_r        <= 1'b0;
         rd_r         <= 1'b0;
         addr_r       <= {DDRAM_AW{1'b0}};
         bcnt_r       <= 8'd0;
      end else begin
         state_r      <= state_s;
         len_r        <= len_s;
         beats_left_r <= beats_left_s;
         discard_r    <= discard_s;
         pending_r    <= pending_s;
         flush_hold_r <= flush_hold_s;
         run_r        <= 1'b1;
         rd_r         <= rd_s;
         addr_r       <= addr_s;
         bcnt_r       <= bcnt_s;
      end
   end

   assign ddram_rd       = rd_r;
   assign ddram_addr     = addr_r;
   assign ddram_burstcnt = bcnt_r;
   assign out_valid      = fifo_valid_s;
   assign out_data       = fifo_head_s[63:0];
   assign out_last       = fifo_head_s[64];

endmodule

// File: tb/tb_pgm_gfx_fetch.sv
// Directed bench for pgm_gfx_fetch: table of burst vectors plus hand-written
// credit, flush and reset sequences, with an output scoreboard.
module tb_pgm_gfx_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [28:0] req_addr = 29'd0;
   logic [3:0]  req_len = 4'd0;
   logic        ddram_rd;
   logic [28:0] ddram_addr;
   logic [7:0]  ddram_burstcnt;
   logic        ddram_busy = 1'b0;
   logic [63:0] ddram_dout = 64'd0;
   logic        ddram_dout_ready = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        out_last;

   int errors = 0;
   int checks = 0;
   logic [64:0] got_q[$];
   logic [64:0] exp_q[$];

   typedef struct {
      logic [28:0] addr;
      logic [3:0]  len;
      int          busy;
      logic [7:0]  exp_len;
   } vec_t;
   vec_t vecs[5];

   pgm_gfx_fetch #(.FIFO_DEPTH(16), .MAX_BURST(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .req_len          (req_len),
      .ddram_rd         (ddram_rd),
      .ddram_addr       (ddram_addr),
      .ddram_burstcnt   (ddram_burstcnt),
      .ddram_busy       (ddram_busy),
      .ddram_dout       (ddram_dout),
      .ddram_dout_ready (ddram_dout_ready),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_last         (out_last)
   );

   always #5 clk = ~clk;

   // Record every head that the consumer actually pops.
   always @(negedge clk) begin
      if (out_valid && out_ready && !flush && !reset) got_q.push_back({out_last, out_data});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [63:0] beat(input int tag, input int i);
      return {32'(tag) * 32'h9E37_79B1, 32'hC0DE_0000 + 32'(i)};
   endfunction

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic issue(input logic [28:0] addr, input logic [3:0] len, input int busy_cyc,
                        input logic [7:0] exp_len);
      bit ok;
      int rdcnt;
      bit stable;
      req_addr  = addr;
      req_len   = len;
      req_valid = 1'b1;
      wait_ready(ok);
      check("req_accept", 65'(ok), 65'd1);
      ddram_busy = (busy_cyc > 0);
      tick();
      req_valid = 1'b0;
      rdcnt  = 0;
      stable = 1'b1;
      for (int c = 0; c < busy_cyc + 3; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("rd_latency", 65'(ddram_rd), 65'd1);
            check("burstcnt", 65'(ddram_burstcnt), 65'(exp_len));
            check("cmd_addr", 65'(ddram_addr), 65'(addr));
         end
         if (ddram_rd) begin
            rdcnt++;
            if (ddram_addr !== addr || ddram_burstcnt !== exp_len) stable = 1'b0;
         end
         tick();
         if (c + 1 >= busy_cyc) ddram_busy = 1'b0;
      end
      check("rd_cycles", 65'(rdcnt), 65'(busy_cyc + 1));
      check("cmd_stable", 65'(stable), 65'd1);
   endtask

   task automatic send_beats(input int tag, input int first, input int cnt, input int total,
                             input bit keep);
      for (int i = first; i < first + cnt; i++) begin
         ddram_dout       = beat(tag, i);
         ddram_dout_ready = 1'b1;
         if (keep) exp_q.push_back({(i == total - 1), beat(tag, i)});
         tick();
      end
      ddram_dout_ready = 1'b0;
      ddram_dout       = 64'd0;
   endtask

   task automatic drain_check(input string name);
      for (int c = 0; c < 100; c++) begin
         if (got_q.size() >= exp_q.size()) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check({name, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(name, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
      tick();
   endtask

   task automatic check_reset_vals(input string name);
      @(negedge clk);
      check({name, "_rd"}, 65'(ddram_rd), 65'd0);
      check({name, "_addr"}, 65'(ddram_addr), 65'd0);
      check({name, "_bcnt"}, 65'(ddram_burstcnt), 65'd0);
      check({name, "_ready"}, 65'(req_ready), 65'd0);
      check({name, "_valid"}, 65'(out_valid), 65'd0);
      check({name, "_data"}, 65'(out_data), 65'd0);
      check({name, "_last"}, 65'(out_last), 65'd0);
   endtask

   initial begin
      bit ok;
      int seen;
      vecs[0] = '{29'h0001000, 4'd4, 0, 8'd4};
      vecs[1] = '{29'h1FFFFFFF, 4'd8, 5, 8'd8};
      vecs[2] = '{29'h0000123, 4'd0, 0, 8'd1};
      vecs[3] = '{29'h0ABCDEF, 4'd15, 2, 8'd8};
      vecs[4] = '{29'h0000040, 4'd1, 0, 8'd1};

      // Power-on reset
      repeat (3) tick();
      check_reset_vals("rst");
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("ready_release0", 65'(req_ready), 65'd0);
      tick();
      @(negedge clk);
      check("ready_release1", 65'(req_ready), 65'd1);
      tick();

      // Table-driven bursts
      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         issue(vecs[v].addr, vecs[v].len, vecs[v].busy, vecs[v].exp_len);
         send_beats(v, 0, 1, int'(vecs[v].exp_len), 1'b1);
         @(negedge clk);
         check("out_latency", 65'(out_valid), 65'd1);
         tick();
         send_beats(v, 1, int'(vecs[v].exp_len) - 1, int'(vecs[v].exp_len), 1'b1);
         drain_check("burst");
      end

      // Credit back-pressure: 8 + 8 fills the FIFO, third waits for 8 pops
      out_ready = 1'b0;
      issue(29'h0003000, 4'd8, 0, 8'd8);
      send_beats(10, 0, 8, 8, 1'b1);
      issue(29'h0003100, 4'd8, 0, 8'd8);
      send_beats(11, 0, 8, 8, 1'b1);
      req_addr  = 29'h0003200;
      req_len   = 4'd8;
      req_valid = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (req_ready) seen++;
         tick();
      end
      check("credit_block", 65'(seen), 65'd0);
      out_ready = 1'b1;
      repeat (7) tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("credit_7pops", 65'(req_ready), 65'd0);
      tick();
      req_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("credit_8pops", 65'(req_ready), 65'd1);
      tick();
      issue(29'h0003200, 4'd8, 0, 8'd8);
      send_beats(12, 0, 8, 8, 1'b1);
      out_ready = 1'b1;
      drain_check("credit");

      // Flush in DATA, coinciding with beat 2 of 8
      out_ready = 1'b0;
      issue(29'h0002000, 4'd8, 0, 8'd8);
      send_beats(5, 0, 2, 8, 1'b0);
      flush            = 1'b1;
      ddram_dout       = beat(5, 2);
      ddram_dout_ready = 1'b1;
      tick();
      flush            = 1'b0;
      ddram_dout_ready = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 65'(out_valid), 65'd0);
      tick();
      send_beats(5, 3, 5, 8, 1'b0);
      @(negedge clk);
      check("flush_ready", 65'(req_ready), 65'd1);
      check("flush_still_empty", 65'(out_valid), 65'd0);
      tick();
      out_ready = 1'b1;
      drain_check("flush_data");
      issue(29'h0002100, 4'd4, 0, 8'd4);
      send_beats(6, 0, 4, 4, 1'b1);
      drain_check("after_flush");

      // Flush while the command is still waiting on busy
      req_addr  = 29'h0004000;
      req_len   = 4'd4;
      req_valid = 1'b1;
      wait_ready(ok);
      check("iss_accept", 65'(ok), 65'd1);
      ddram_busy = 1'b1;
      tick();
      req_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("issue_flush_rd", 65'(ddram_rd), 65'd1);
      tick();
      ddram_busy = 1'b0;
      tick();
      @(negedge clk);
      check("issue_flush_rd_off", 65'(ddram_rd), 65'd0);
      tick();
      send_beats(7, 0, 4, 4, 1'b0);
      @(negedge clk);
      check("issue_flush_ready", 65'(req_ready), 65'd1);
      tick();
      drain_check("issue_flush");

      // Reset in the middle of a burst
      out_ready = 1'b0;
      issue(29'h0005000, 4'd4, 0, 8'd4);
      send_beats(20, 0, 2, 4, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_vals("mid_rst");
      tick();
      @(negedge clk);
      check("mid_rst_ready", 65'(req_ready), 65'd1);
      tick();
      out_ready = 1'b1;
      send_beats(20, 2, 2, 4, 1'b0);
      drain_check("mid_rst");

      // Normal operation afterwards
      issue(29'h0001000, 4'd4, 0, 8'd4);
      send_beats(30, 0, 4, 4, 1'b1);
      drain_check("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
